// File: rtl/dl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dl_pkg
//  Description : Shared types and constants for the ioctl download sequencer:
//                sequencer states, ioctl index codes, mod codes and the
//                bit positions of the one-hot mod select.
//  Revision    : 1.0 - initial release
// ============================================================================
package dl_pkg;

    // Core-reset sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // core running
        ST_LOAD   = 2'd1,   // download in progress, core held in reset
        ST_SETTLE = 2'd2    // download finished, counting settle period
    } dl_state_t;

    // ioctl_index codes
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    // Mod byte codes as written by the HPS
    localparam logic [7:0] MOD_DK         = 8'd0;
    localparam logic [7:0] MOD_DKJR       = 8'd1;
    localparam logic [7:0] MOD_DK3        = 8'd2;
    localparam logic [7:0] MOD_RADARSCOPE = 8'd3;
    localparam logic [7:0] MOD_PESTPLACE  = 8'd4;

    // Bit positions inside mod_onehot = {pestplace,radarscope,dk3,dkjr,dk}
    localparam int MOD_W           = 5;
    localparam int MODB_DK         = 0;
    localparam int MODB_DKJR       = 1;
    localparam int MODB_DK3        = 2;
    localparam int MODB_RADARSCOPE = 3;
    localparam int MODB_PESTPLACE  = 4;

    // Unknown mod codes select no variant at all rather than a default one,
    // so the core can detect an unsupported MRA.
    function automatic logic [MOD_W-1:0] mod_to_onehot(input logic [7:0] code);
        logic [MOD_W-1:0] oh;
        oh = '0;
        case (code)
            MOD_DK:         oh[MODB_DK]         = 1'b1;
            MOD_DKJR:       oh[MODB_DKJR]       = 1'b1;
            MOD_DK3:        oh[MODB_DK3]        = 1'b1;
            MOD_RADARSCOPE: oh[MODB_RADARSCOPE] = 1'b1;
            MOD_PESTPLACE:  oh[MODB_PESTPLACE]  = 1'b1;
            default:        oh                  = '0;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dl_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : dl_region_decode
//  Description : Combinational ROM address map. Classifies a 25-bit ioctl
//                byte address into the main, sound or wave ROM region and
//                returns the region-relative address. Regions are tested in
//                the order main, sound, wave so at most one hit is asserted.
//  Revision    : 1.0 - initial release
// ============================================================================
module dl_region_decode #(
    parameter logic [15:0] MAIN_END = 16'h8000,
    parameter logic [15:0] SND_BASE = 16'hE000,
    parameter logic [15:0] SND_END  = 16'hF000,
    parameter logic [15:0] WAV_BASE = 16'hFF00
) (
    input  logic [24:0] i_addr,
    output logic        o_hit_main,
    output logic        o_hit_snd,
    output logic        o_hit_wav,
    output logic        o_hit_any,
    output logic [15:0] o_rel_addr
);

    logic        w_in_page0;
    logic [15:0] w_lo;

    // All ROM regions live in the first 64 KiB of the download image
    assign w_in_page0 = (i_addr[24:16] == 9'd0);
    assign w_lo       = i_addr[15:0];

    // Priority region match and rebase to the region's own address space
    always_comb begin
        o_hit_main = 1'b0;
        o_hit_snd  = 1'b0;
        o_hit_wav  = 1'b0;
        o_rel_addr = w_lo;
        if (w_in_page0) begin
            if (w_lo < MAIN_END) begin
                o_hit_main = 1'b1;
                o_rel_addr = w_lo;
            end else if ((w_lo >= SND_BASE) && (w_lo < SND_END)) begin
                o_hit_snd  = 1'b1;
                o_rel_addr = w_lo - SND_BASE;
            end else if (w_lo >= WAV_BASE) begin
                o_hit_wav  = 1'b1;
                o_rel_addr = w_lo - WAV_BASE;
            end
        end
    end

    assign o_hit_any = o_hit_main | o_hit_snd | o_hit_wav;

endmodule
`default_nettype wire

// File: rtl/rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_dl_sequencer
//  Description : Single controller between the HPS ioctl download stream and
//                the core. Decodes ioctl writes into registered ROM write
//                strobes (main / sound / wave), the mod byte and the DIP
//                bytes, tracks download status, and sequences core reset
//                through downloads, soft resets and a settle period.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_sequencer
    import dl_pkg::*;
#(
    parameter logic [15:0] MAIN_END      = 16'h8000,
    parameter logic [15:0] SND_BASE      = 16'hE000,
    parameter logic [15:0] SND_END       = 16'hF000,
    parameter logic [15:0] WAV_BASE      = 16'hFF00,
    parameter int          SETTLE_CYCLES = 1024
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             soft_reset,
    input  logic             ioctl_download,
    input  logic             ioctl_wr,
    input  logic [7:0]       ioctl_index,
    input  logic [24:0]      ioctl_addr,
    input  logic [7:0]       ioctl_dout,
    output logic [15:0]      rom_addr,
    output logic [7:0]       rom_data,
    output logic             main_we,
    output logic             snd_we,
    output logic             wav_we,
    output logic [63:0]      dip,
    output logic [MOD_W-1:0] mod_onehot,
    output logic             core_reset_n,
    output logic             rom_loaded,
    output logic [15:0]      drop_cnt
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]       DROP_MAX    = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    dl_state_t        r_state;
    dl_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_settle_cnt;
    logic [CNT_W-1:0] w_settle_cnt_nxt;
    logic             r_core_reset_n;

    logic [15:0]      r_rom_addr;
    logic [7:0]       r_rom_data;
    logic             r_main_we;
    logic             r_snd_we;
    logic             r_wav_we;
    logic [63:0]      r_dip;
    logic [7:0]       r_mod;
    logic             r_rom_loaded;
    logic [15:0]      r_drop_cnt;

    // ------------------------------------------------------------------------
    // Write qualification and address decode
    // ------------------------------------------------------------------------
    logic        w_wr_ok;
    logic        w_rom_wr;
    logic        w_mod_wr;
    logic        w_dip_wr;
    logic        w_load_entry;
    logic        w_hit_main;
    logic        w_hit_snd;
    logic        w_hit_wav;
    logic        w_hit_any;
    logic [15:0] w_rel_addr;
    logic        w_rom_loaded_nxt;
    logic [15:0] w_drop_cnt_nxt;

    // A write is only taken while download is high, so the strobe that
    // coincides with the falling edge of download is discarded.
    assign w_wr_ok  = ioctl_wr & ioctl_download;
    assign w_rom_wr = w_wr_ok & (ioctl_index == IDX_ROM);
    assign w_mod_wr = w_wr_ok & (ioctl_index == IDX_MOD);
    assign w_dip_wr = w_wr_ok & (ioctl_index == IDX_DIP) & (ioctl_addr[24:3] == 22'd0);

    // First cycle of a ROM download: status from the previous image is stale
    assign w_load_entry = ioctl_download & (r_state != ST_LOAD) & (ioctl_index == IDX_ROM);

    dl_region_decode #(
        .MAIN_END (MAIN_END),
        .SND_BASE (SND_BASE),
        .SND_END  (SND_END),
        .WAV_BASE (WAV_BASE)
    ) u_region_decode (
        .i_addr     (ioctl_addr),
        .o_hit_main (w_hit_main),
        .o_hit_snd  (w_hit_snd),
        .o_hit_wav  (w_hit_wav),
        .o_hit_any  (w_hit_any),
        .o_rel_addr (w_rel_addr)
    );

    // ------------------------------------------------------------------------
    // Core reset sequencer
    // ------------------------------------------------------------------------

    // State register; core_reset_n is registered from the next state so the
    // core sees a glitch-free reset line aligned with the state change.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_SETTLE;
            r_settle_cnt   <= '0;
            r_core_reset_n <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_settle_cnt   <= w_settle_cnt_nxt;
            r_core_reset_n <= (w_state_nxt == ST_IDLE);
        end
    end

    // Next-state and settle counter; an active download overrides any state
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        if (ioctl_download) begin
            w_state_nxt      = ST_LOAD;
            w_settle_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    w_state_nxt      = ST_SETTLE;
                    w_settle_cnt_nxt = '0;
                end
                ST_SETTLE: begin
                    if (soft_reset) begin
                        w_settle_cnt_nxt = '0;
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_nxt      = ST_IDLE;
                        w_settle_cnt_nxt = '0;
                    end else begin
                        w_settle_cnt_nxt = r_settle_cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (soft_reset) begin
                        w_state_nxt      = ST_SETTLE;
                        w_settle_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt      = ST_SETTLE;
                    w_settle_cnt_nxt = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // ROM write path
    // ------------------------------------------------------------------------

    // Strobes are single-cycle; address/data only move when a strobe fires
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_main_we  <= 1'b0;
            r_snd_we   <= 1'b0;
            r_wav_we   <= 1'b0;
            r_rom_addr <= '0;
            r_rom_data <= '0;
        end else begin
            r_main_we <= w_rom_wr & w_hit_main;
            r_snd_we  <= w_rom_wr & w_hit_snd;
            r_wav_we  <= w_rom_wr & w_hit_wav;
            if (w_rom_wr && w_hit_any) begin
                r_rom_addr <= w_rel_addr;
                r_rom_data <= ioctl_dout;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Download status
    // ------------------------------------------------------------------------

    // Entry clear is applied first so a write in the entry cycle still counts
    always_comb begin
        w_rom_loaded_nxt = w_load_entry ? 1'b0  : r_rom_loaded;
        w_drop_cnt_nxt   = w_load_entry ? 16'd0 : r_drop_cnt;
        if (w_rom_wr && w_hit_main) begin
            w_rom_loaded_nxt = 1'b1;
        end
        if (w_rom_wr && !w_hit_any && (w_drop_cnt_nxt != DROP_MAX)) begin
            w_drop_cnt_nxt = w_drop_cnt_nxt + 16'd1;
        end
    end

    // Status registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_loaded <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_rom_loaded <= w_rom_loaded_nxt;
            r_drop_cnt   <= w_drop_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Mod and DIP registers
    // ------------------------------------------------------------------------

    // Mod byte latch and DIP byte lanes addressed by ioctl_addr[2:0]
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mod <= MOD_DK;
            r_dip <= '0;
        end else begin
            if (w_mod_wr) begin
                r_mod <= ioctl_dout;
            end
            if (w_dip_wr) begin
                r_dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rom_addr     = r_rom_addr;
    assign rom_data     = r_rom_data;
    assign main_we      = r_main_we;
    assign snd_we       = r_snd_we;
    assign wav_we       = r_wav_we;
    assign dip          = r_dip;
    assign mod_onehot   = mod_to_onehot(r_mod);
    assign core_reset_n = r_core_reset_n;
    assign rom_loaded   = r_rom_loaded;
    assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_dl_sequencer
//  Description : Self-checking bench for rom_dl_sequencer. A behavioural model
//                tracks the expected outputs from the address map, write rules
//                and a run-length view of the reset hold-off; every cycle the
//                DUT is compared against it, and directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dl_sequencer;

    localparam int SETTLE = 1024;

    logic        clk_sys;
    logic        reset_n;
    logic        soft_reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        main_we;
    logic        snd_we;
    logic        wav_we;
    logic [63:0] dip;
    logic [4:0]  mod_onehot;
    logic        core_reset_n;
    logic        rom_loaded;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .soft_reset     (soft_reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .main_we        (main_we),
        .snd_we         (snd_we),
        .wav_we         (wav_we),
        .dip            (dip),
        .mod_onehot     (mod_onehot),
        .core_reset_n   (core_reset_n),
        .rom_loaded     (rom_loaded),
        .drop_cnt       (drop_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int       m_rom_addr = 0;
    int       m_rom_data = 0;
    bit       m_main = 0, m_snd = 0, m_wav = 0;
    int       m_dip [8] = '{default: 0};
    int       m_mod = 0;
    bit       m_loaded = 0;
    int       m_drop = 0;
    int       m_run = 0;      // consecutive cycles free of any reset-hold cause
    bit       m_prev_dl = 0;
    int       m_a;

    function automatic logic [63:0] exp_dip();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = 8'(m_dip[i]);
        return v;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_rom_addr = 0; m_rom_data = 0;
            m_main = 0; m_snd = 0; m_wav = 0;
            for (int i = 0; i < 8; i++) m_dip[i] = 0;
            m_mod = 0; m_loaded = 0; m_drop = 0; m_run = 0; m_prev_dl = 0;
        end else begin
            m_main = 0; m_snd = 0; m_wav = 0;
            if (ioctl_download && !m_prev_dl && ioctl_index == 8'd0) begin
                m_loaded = 0;
                m_drop   = 0;
            end
            if (ioctl_wr && ioctl_download) begin
                m_a = int'(ioctl_addr);
                if (ioctl_index == 8'd0) begin
                    if (m_a < 'h8000) begin
                        m_main = 1; m_rom_addr = m_a; m_rom_data = ioctl_dout; m_loaded = 1;
                    end else if (m_a >= 'hE000 && m_a < 'hF000) begin
                        m_snd = 1; m_rom_addr = m_a - 'hE000; m_rom_data = ioctl_dout;
                    end else if (m_a >= 'hFF00 && m_a <= 'hFFFF) begin
                        m_wav = 1; m_rom_addr = m_a - 'hFF00; m_rom_data = ioctl_dout;
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                end else if (ioctl_index == 8'd1) begin
                    m_mod = ioctl_dout;
                end else if (ioctl_index == 8'd254 && m_a < 8) begin
                    m_dip[m_a] = ioctl_dout;
                end
            end
            // Download, the cycle it ends, and soft reset all restart the hold-off
            if (ioctl_download || soft_reset || m_prev_dl) m_run = 0;
            else if (m_run < SETTLE) m_run++;
            m_prev_dl = ioctl_download;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk_sys) begin
        chk("main_we",      64'(main_we),      64'(m_main));
        chk("snd_we",       64'(snd_we),       64'(m_snd));
        chk("wav_we",       64'(wav_we),       64'(m_wav));
        chk("rom_addr",     64'(rom_addr),     64'(m_rom_addr));
        chk("rom_data",     64'(rom_data),     64'(m_rom_data));
        chk("dip",          dip,               exp_dip());
        chk("mod_onehot",   64'(mod_onehot),   (m_mod < 5) ? (64'd1 << m_mod) : 64'd0);
        chk("core_reset_n", 64'(core_reset_n), 64'(m_run >= SETTLE));
        chk("rom_loaded",   64'(rom_loaded),   64'(m_loaded));
        chk("drop_cnt",     64'(drop_cnt),     64'(m_drop));
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all driven just after the falling edge)
    // ------------------------------------------------------------------------
    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_index = idx;
    endtask

    task automatic end_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
    endtask

    // Counts falling edges until core_reset_n goes high; bounded
    task automatic wait_release(input string name, input int exp_n, output bit strobe_seen);
        int n;
        n = 0;
        strobe_seen = 0;
        while (core_reset_n !== 1'b1 && n < 4000) begin
            @(negedge clk_sys);
            n++;
            if (main_we || snd_we || wav_we) strobe_seen = 1;
        end
        chk(name, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    bit seen;

    initial begin
        reset_n = 1'b0; soft_reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(negedge clk_sys);

        // Reset values
        chk("rst core_reset_n", 64'(core_reset_n), 64'd0);
        chk("rst mod_onehot",   64'(mod_onehot),   64'b00001);
        chk("rst dip",          dip,               64'd0);
        chk("rst drop_cnt",     64'(drop_cnt),     64'd0);
        reset_n = 1'b1;
        wait_release("release after reset", SETTLE, seen);

        // ROM download; first write coincides with download rising
        @(negedge clk_sys);
        ioctl_download = 1'b1; ioctl_index = 8'd0;
        ioctl_wr = 1'b1; ioctl_addr = 25'h0000; ioctl_dout = 8'hAA;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("lit main_we",   64'(main_we),  64'd1);
        chk("lit main addr", 64'(rom_addr), 64'h0000);
        chk("lit main data", 64'(rom_data), 64'hAA);
        chk("lit core held", 64'(core_reset_n), 64'd0);
        wr_byte(25'hE005, 8'h55);
        chk("lit snd_we",    64'(snd_we),   64'd1);
        chk("lit snd addr",  64'(rom_addr), 64'h0005);
        wr_byte(25'hFF10, 8'h33);
        chk("lit wav_we",    64'(wav_we),   64'd1);
        chk("lit wav addr",  64'(rom_addr), 64'h0010);
        wr_byte(25'h9000, 8'h11);
        chk("lit gap strobes", 64'({main_we, snd_we, wav_we}), 64'd0);
        chk("lit drop 1",    64'(drop_cnt), 64'd1);
        chk("lit loaded",    64'(rom_loaded), 64'd1);
        wr_byte(25'h1_0000, 8'h22);
        chk("lit drop page", 64'(drop_cnt), 64'd2);
        // Write on the falling edge of download must be discarded
        @(negedge clk_sys);
        ioctl_download = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 25'h0001; ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("lit fall no we", 64'(main_we),  64'd0);
        chk("lit fall data",  64'(rom_data), 64'h33);

        // Mod byte
        start_dl(8'd1);
        wr_byte(25'd0, 8'h03);
        chk("lit mod 3", 64'(mod_onehot), 64'b01000);
        wr_byte(25'd5, 8'h07);
        chk("lit mod 7", 64'(mod_onehot), 64'b00000);
        end_dl();
        chk("lit mod keeps loaded", 64'(rom_loaded), 64'd1);

        // DIP bytes
        start_dl(8'd254);
        wr_byte(25'd2, 8'h5A);
        wr_byte(25'd8, 8'hFF);
        chk("lit dip", dip, 64'h0000_0000_005A_0000);
        chk("lit dip no drop", 64'(drop_cnt), 64'd2);
        end_dl();

        // Restart download in the middle of the settle period
        repeat (500) @(negedge clk_sys);
        chk("lit mid settle held", 64'(core_reset_n), 64'd0);
        ioctl_download = 1'b1; ioctl_index = 8'd254;
        repeat (5) @(negedge clk_sys);
        chk("lit reload held", 64'(core_reset_n), 64'd0);
        ioctl_download = 1'b0;
        wait_release("release after abort", SETTLE + 1, seen);

        // Soft reset pulse while running
        @(negedge clk_sys);
        soft_reset = 1'b1;
        @(negedge clk_sys);
        chk("lit soft immediate", 64'(core_reset_n), 64'd0);
        repeat (9) @(negedge clk_sys);
        soft_reset = 1'b0;
        wait_release("release after soft", SETTLE, seen);
        chk("lit soft no strobe", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a download write
        start_dl(8'd0);
        wr_byte(25'h0100, 8'h77);
        @(negedge clk_sys);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0200; ioctl_dout = 8'h99;
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("lit async we", 64'(main_we), 64'd0);
        chk("lit async addr", 64'(rom_addr), 64'd0);
        @(negedge clk_sys);
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        chk("lit async loaded", 64'(rom_loaded), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        wait_release("release after async", SETTLE, seen);

        repeat (4) @(negedge clk_sys);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_dl_sequencer.md
Name: rom_dl_sequencer

Overview:
- Sits between the HPS ioctl download stream and the core's ROM dual-port RAMs, DIP/mod registers and core reset.
- Decodes each ioctl write into one of three ROM regions (main CPU, sound CPU, wave), the mod byte or DIP bytes, and issues registered write strobes.
- Sequences core reset: holds the core in reset through a download and a programmable settle period, then releases it.
- Replaces the scattered ad-hoc write-enable decoding in the top level with one controller.

Parameters:
- MAIN_END, 16'h8000, exclusive upper bound of the main ROM region (base 0).
- SND_BASE, 16'hE000, inclusive base of the sound ROM region.
- SND_END, 16'hF000, exclusive upper bound of the sound ROM region.
- WAV_BASE, 16'hFF00, inclusive base of the wave ROM region (runs to 16'hFFFF).
- SETTLE_CYCLES, 1024, clk_sys cycles that core reset is held after a download or soft reset ends.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- soft_reset  in  1  level reset request (OSD/user button); re-arms settle
- ioctl_download  in  1  download active
- ioctl_wr  in  1  one-cycle write strobe
- ioctl_index  in  8  0=ROM, 1=mod byte, 254=DIP
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- rom_addr  out  16  registered write address (region-relative for sound/wave)
- rom_data  out  8  registered write data
- main_we, snd_we, wav_we  out  1 each  one-cycle region write strobes
- dip  out  64  DIP bytes 0..7 packed, byte n at [8n+7:8n]
- mod_onehot  out  5  {pestplace,radarscope,dk3,dkjr,dk}
- core_reset_n  out  1  active-low reset to core
- rom_loaded  out  1  at least one main-region byte received in the last index-0 download
- drop_cnt  out  16  saturating count of index-0 writes outside every region

Behaviour:
- Reset values: rom_addr=0, rom_data=0, all *_we=0, dip=0, mod_onehot=5'b00001, core_reset_n=0, rom_loaded=0, drop_cnt=0, state=SETTLE, settle counter=0.
- Only the stated reset is asynchronous; all other logic is synchronous to clk_sys.
- FSM states:
  - IDLE: core running; core_reset_n=1.
  - LOAD: ioctl_download=1; core_reset_n=0.
  - SETTLE: counting; core_reset_n=0.
- Transitions:
  - Any state: ioctl_download=1 → LOAD. On LOAD entry with ioctl_index=0, clear rom_loaded and drop_cnt.
  - LOAD: ioctl_download=0 → SETTLE, counter cleared.
  - SETTLE: soft_reset=1 holds the counter at 0. Counter reaching SETTLE_CYCLES-1 → IDLE.
  - IDLE: soft_reset=1 → SETTLE.
- Write decode. Applies only when ioctl_wr=1 and ioctl_download=1; latency is 1 cycle (strobe and rom_addr/rom_data registered together).
  - Index 0: ROM regions require ioctl_addr[24:16]==0.
    - addr<MAIN_END → main_we, rom_addr=addr.
    - SND_BASE≤addr<SND_END → snd_we, rom_addr=addr-SND_BASE.
    - addr≥WAV_BASE → wav_we, rom_addr=addr-WAV_BASE.
    - Anything else → no strobe; drop_cnt+1, saturating at 16'hFFFF.
  - Regions are checked in the order main, snd, wav; at most one strobe fires per write.
  - A main write sets rom_loaded.
  - Index 1: any address; mod latches ioctl_dout. mod_onehot updates the next cycle: 0..4 maps to one bit; values ≥5 give all zeros.
  - Index 254: ioctl_addr[24:3]==0 → dip byte ioctl_addr[2:0] updated; otherwise ignored, not counted.
  - Other indices: ignored.
- Simultaneous events:
  - ioctl_wr in the same cycle as the ioctl_download falling edge is not accepted; decode requires download=1.
  - A write in the cycle download rises is accepted.
- Download restarting during SETTLE aborts the settle and returns to LOAD.
- reset_n low mid-download: all state is lost; no partial strobe is emitted.
- No strobe pulse exceeds one cycle. rom_addr/rom_data hold their last values when idle.

Decomposition:
- Shared package `dl_pkg`: state enum (IDLE, LOAD, SETTLE), index constants (IDX_ROM=0, IDX_MOD=1, IDX_DIP=254), mod code constants, mod_onehot bit positions.
- One sub-module is natural: `dl_region_decode` (combinational address → region select plus relative address), reusable by the upload path.

Test Plan:
- Reset, idle 1024 cycles with download=0 → core_reset_n rises exactly SETTLE_CYCLES cycles after reset_n release; mod_onehot=00001.
- Download idx 0, writes at 0x0000=0xAA, 0xE005=0x55, 0xFF10=0x33, 0x9000=0x11 → main_we rom_addr 0x0000 data 0xAA; snd_we rom_addr 0x0005; wav_we rom_addr 0x0010; no strobe for 0x9000, drop_cnt=1; rom_loaded=1.
- Download idx 1 data 0x03 → mod_onehot=01000. Then data 0x07 → 00000.
- Download idx 254, addr 2 data 0x5A, then addr 8 data 0xFF → dip[23:16]=0x5A; other dip bytes unchanged.
- During SETTLE at count 500, raise download → state LOAD, core_reset_n stays 0. Drop download → full SETTLE_CYCLES recount before release.
- In IDLE, pulse soft_reset for 10 cycles → core_reset_n=0 immediately. Release occurs SETTLE_CYCLES cycles after soft_reset falls; ROM strobes stay 0 throughout.
